// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: parses a counted big-endian byte stream,
// writes 32-bit words into imem and holds the core in reset until the checksum is good.
module imem_loader #(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [31:0]           imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam logic [32:0]       DEPTH  = 33'd1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] WL_ONE = 1;

  typedef enum logic [2:0] {
    S_HDR_HI, S_HDR_LO, S_DATA, S_CSUM, S_DONE, S_ERROR
  } state_t;

  state_t      state, state_n;
  logic [7:0]  count_hi;
  logic [15:0] count;
  logic [23:0] shreg;     // first three bytes of the word in flight
  logic [1:0]  byte_idx;
  logic [7:0]  sum;

  logic        accept, wr, clr, last_word;
  logic [7:0]  sum_n;
  logic [15:0] hdr;
  logic [31:0] word_n, addr_n;

  assign byte_ready = (state == S_HDR_HI) || (state == S_HDR_LO) ||
                      (state == S_DATA)   || (state == S_CSUM);
  assign done       = (state == S_DONE);
  assign error      = (state == S_ERROR);
  assign cpu_reset  = (state != S_DONE);

  assign accept    = byte_valid && byte_ready;
  assign sum_n     = sum + byte_data;
  assign hdr       = {count_hi, byte_data};
  assign word_n    = {shreg, byte_data};
  assign addr_n    = BASE_ADDR + (32'(words_loaded) << 2);
  // words_loaded still counts the previous word when the 4th byte arrives
  assign last_word = (32'(words_loaded) + 32'd1) == 32'(count);

  always_comb begin
    state_n = state;
    wr      = 1'b0;
    clr     = 1'b0;
    unique case (state)
      S_HDR_HI: if (accept) state_n = S_HDR_LO;
      S_HDR_LO: begin
        if (accept) begin
          if (33'(hdr) > DEPTH)  state_n = S_ERROR;
          else if (hdr == 16'd0) state_n = S_CSUM;
          else                   state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (accept && byte_idx == 2'd3) begin
          wr = 1'b1;
          if (last_word) state_n = S_CSUM;
        end
      end
      S_CSUM: if (accept) state_n = (sum_n == 8'h00) ? S_DONE : S_ERROR;
      S_DONE, S_ERROR: begin
        if (start) begin
          state_n = S_HDR_HI;
          clr     = 1'b1;
        end
      end
      default: state_n = S_HDR_HI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_HDR_HI;
      count_hi     <= '0;
      count        <= '0;
      shreg        <= '0;
      byte_idx     <= '0;
      sum          <= '0;
      words_loaded <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
    end else begin
      state   <= state_n;
      imem_we <= wr;
      if (accept) begin
        sum <= sum_n;
        if (state == S_HDR_HI) count_hi <= byte_data;
        if (state == S_HDR_LO) count    <= hdr;
        if (state == S_DATA) begin
          shreg    <= {shreg[15:0], byte_data};
          byte_idx <= byte_idx + 2'd1;
        end
      end
      if (wr) begin
        imem_addr    <= addr_n;
        imem_wdata   <= word_n;
        words_loaded <= words_loaded + WL_ONE;
      end
      if (clr) begin
        words_loaded <= '0;
        sum          <= '0;
        byte_idx     <= '0;
      end
    end
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that is the writer side of the instruction memory the single-cycle MIPS core fetches from. It accepts a byte stream over a valid/ready handshake, parses a word-count header, assembles big-endian 32-bit instructions and writes them into the instruction memory write port. It validates a trailing checksum and holds the core in reset until a complete, valid image has been loaded.

## Interface

Parameters:
- ADDR_WIDTH, 8, word-address width of the instruction memory; DEPTH = 2**ADDR_WIDTH words.
- BASE_ADDR, 32'h0000_0000, byte address of the first loaded word; must be word-aligned.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; restarts a load from DONE or ERROR.
- byte_valid  input  1  byte_data is valid this cycle.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts a byte this cycle.
- imem_we  output  1  instruction-memory write strobe, one cycle per word.
- imem_addr  output  32  byte address of the write, word-aligned.
- imem_wdata  output  32  instruction word.
- cpu_reset  output  1  holds the MIPS core in reset while high.
- done  output  1  image loaded and checksum correct.
- error  output  1  load aborted (checksum mismatch or oversize count).
- words_loaded  output  ADDR_WIDTH+1  number of words written in the current load.

## Operation

- Byte transfer occurs on a rising edge where byte_valid && byte_ready. Bytes offered while byte_ready=0 are not consumed. The source must hold them.
- Stream format: count_hi, count_lo (16-bit word count N, big-endian), then 4*N payload bytes (each word MSB first), then one checksum byte.
- Checksum rule: the 8-bit modulo-256 sum of every byte must equal 8'h00. This covers both header bytes, all payload bytes and the checksum byte.
- States:
  - HDR_HI: accept count_hi and go to HDR_LO.
  - HDR_LO: accept count_lo.
    - If N > DEPTH, go to ERROR.
    - If N == 0, go to CSUM.
    - Otherwise go to DATA.
  - DATA: shift bytes into a 32-bit assembly register and keep a 2-bit byte index.
    - On the 4th byte, issue a write and increment words_loaded.
    - After word N is written, go to CSUM.
  - CSUM: accept one byte.
    - If the running sum including this byte is 0, go to DONE.
    - Otherwise go to ERROR.
  - DONE and ERROR: terminal. start returns the block to HDR_HI, clears words_loaded, the running sum and the byte index, and re-asserts cpu_reset.
- byte_ready = 1 in HDR_HI, HDR_LO, DATA and CSUM; 0 in DONE and ERROR.
- Write address for word i (0-based) = BASE_ADDR + 4*i. Addresses are 32-bit and never wrap within a legal load, because N ≤ DEPTH.
- cpu_reset = 1 in every state except DONE.
- done = 1 only in DONE. error = 1 only in ERROR.
- start is ignored in HDR_HI, HDR_LO, DATA and CSUM.
- reset has priority over start and over byte acceptance.
- Reset mid-load: the partial word is discarded, no write is issued, and state returns to HDR_HI. Memory contents already written are not cleared.

## Timing

- Reset values: state HDR_HI, byte_ready 1 (decoded from state), imem_we 0, imem_addr 0, imem_wdata 0, cpu_reset 1, done 0, error 0, words_loaded 0.
- imem_we, imem_addr and imem_wdata are registered.
  - On the edge that accepts the 4th byte of a word, they are loaded.
  - imem_we is high for exactly the following cycle, then returns to 0.
  - imem_addr and imem_wdata hold their values until the next write.
- Throughput: one byte per cycle sustained; back-to-back words give imem_we high every 4th cycle.
- done, error and cpu_reset change on the edge that accepts the checksum byte (or count_lo, for an oversize count). They are visible the next cycle.
- The final word's imem_we cycle coincides with the CSUM state. The checksum byte may be accepted in that same cycle.
- words_loaded increments on the same edge that loads imem_we.
- start sampled in DONE or ERROR: state is HDR_HI on the next cycle, with cpu_reset=1 and done/error=0.

## Test plan

- Nominal load, BASE_ADDR=0. Stream 00 02 20 08 00 05 AC 08 00 00 1D, one byte per cycle. Required:
  - imem_we pulses twice: addr 0x00 / data 0x20080005, then addr 0x04 / data 0xAC080000.
  - done=1, cpu_reset=0, words_loaded=2.
- Bad checksum: same stream with last byte 1E. Required:
  - Both writes still occur.
  - error=1, done=0, cpu_reset=1, byte_ready=0.
- Oversize count with ADDR_WIDTH=8: header 01 01 (N=257). Required: error=1 after count_lo, no imem_we, byte_ready=0.
- Handshake gaps: nominal stream with byte_valid randomly low 50% of cycles. Required: identical writes and done=1. While byte_valid=0 the byte index, sum and state are unchanged.
- Empty image: 00 00 00. Required: done=1, zero writes, words_loaded=0.
- Reset mid-word, then restart:
  - Assert reset after 2 payload bytes of word 0. Required: no write, state HDR_HI, all outputs at reset values.
  - Then feed the full nominal stream. Required: done.
  - Then pulse start. Required: cpu_reset=1 and done=0 on the next cycle.
